// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic feeder, controller and PE array.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the default array geometry so all three blocks agree on lane count
// and element width, plus the 2-bit feeder FSM state encoding.
package systolic_skew_feeder_pkg;

    localparam int LANES_DEFAULT  = 10;
    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10
    } feeder_state_e;

    // Drain counter must hold LANES-1; a single lane still needs one bit.
    function automatic int drain_cnt_width(input int lanes);
        int w;
        w = $clog2(lanes);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth shift register used to skew one lane of the feeder.
// Latency: DEPTH cycles; DEPTH=0 is a plain wire.
// Backpressure: none; every stage shifts every cycle, clr_i zeroes all stages.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of every stage
//   d_i / q_o     : WIDTH-bit input and DEPTH-cycle delayed output
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        // No storage: clock, reset and clear have nothing to act on.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk_i, rst_ni, clr_i};
        assign q_o = d_i;
    end else begin : g_stages
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
            if (!clr_i) begin
                stage_d[0] = d_i;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= stage_d[i];
                end
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Triangular skew feeder between a global-buffer read port and the PE array edge.
// Latency: lane k output is the ingress sample from k+1 cycles earlier (1..LANES).
// Backpressure: none; the pipeline never stalls, bubbles travel as invalid zeros.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ensys_i       : controller systolic enable, high while a batch streams
//   bubble_i      : inject an invalid zero sample this cycle
//   clr_i         : synchronous clear of all stages and FSM state
//   data_i        : LANES x DATA_W buffer word, lane k at [k*DATA_W +: DATA_W]
//   data_o        : skewed lanes, zero whenever the lane is not valid
//   valid_o       : per-lane real-sample flag
//   busy_o        : FSM in ACTIVE or DRAIN
//   drained_o     : single-cycle pulse in the last DRAIN cycle
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int LANES  = LANES_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ensys_i,
    input  logic                    bubble_i,
    input  logic                    clr_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [LANES-1:0]        valid_o,
    output logic                    busy_o,
    output logic                    drained_o
);

    localparam int CNT_W = drain_cnt_width(LANES);
    // Each stage carries {valid, value} so both travel in lockstep.
    localparam int SMP_W = DATA_W + 1;

    // ------------------------------------------------------------------
    // Ingress register: one {valid, value} per lane
    // ------------------------------------------------------------------
    logic             sample_vld;
    logic [SMP_W-1:0] ing_d [LANES];
    logic [SMP_W-1:0] ing_q [LANES];
    logic [SMP_W-1:0] lane_q [LANES];

    // A clear discards this cycle's sample as well as everything queued.
    assign sample_vld = ensys_i & ~bubble_i & ~clr_i;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            ing_d[k] = '0;
            if (sample_vld) begin
                ing_d[k] = {1'b1, data_i[k*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < LANES; k++) begin
                ing_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                ing_q[k] <= ing_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-lane skew: lane k adds k stages after the ingress register
    // ------------------------------------------------------------------
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        skew_delay_line #(
            .DEPTH (k),
            .WIDTH (SMP_W)
        ) u_delay (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr_i),
            .d_i    (ing_q[k]),
            .q_o    (lane_q[k])
        );

        assign valid_o[k] = lane_q[k][DATA_W];
        // Masked so the PEs never see a stale value on an invalid lane.
        assign data_o[k*DATA_W +: DATA_W] =
            lane_q[k][DATA_W] ? lane_q[k][DATA_W-1:0] : '0;
    end

    // ------------------------------------------------------------------
    // Batch FSM
    // ------------------------------------------------------------------
    feeder_state_e    state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             drained_d;

    // DRAIN lasts LANES-1 cycles: exactly the time the deepest lane needs
    // to flush its queued samples after the last ingress word.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        drained_d   = 1'b0;

        if (clr_i) begin
            state_d     = IDLE;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ensys_i) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!ensys_i) begin
                        state_d     = DRAIN;
                        drain_cnt_d = CNT_W'(LANES - 1);
                    end
                end
                DRAIN: begin
                    if (ensys_i) begin
                        // New batch joins behind the queued samples.
                        state_d = ACTIVE;
                    end else begin
                        if (drain_cnt_q != '0) begin
                            drain_cnt_d = drain_cnt_q - CNT_W'(1);
                        end
                        if (drain_cnt_d == '0) begin
                            state_d   = IDLE;
                            drained_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign drained_o = drained_d;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

    localparam int LA = 10;
    localparam int WA = 8;
    localparam int LB = 4;
    localparam int WB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic             ens_a, bub_a, clr_a, busy_a, drn_a;
    logic [LA*WA-1:0] din_a, dout_a;
    logic [LA-1:0]    vld_a;

    logic             ens_b, bub_b, clr_b, busy_b, drn_b;
    logic [LB*WB-1:0] din_b, dout_b;
    logic [LB-1:0]    vld_b;

    systolic_skew_feeder #(.LANES(LA), .DATA_W(WA)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .ensys_i(ens_a), .bubble_i(bub_a),
        .clr_i(clr_a), .data_i(din_a), .data_o(dout_a), .valid_o(vld_a),
        .busy_o(busy_a), .drained_o(drn_a)
    );

    systolic_skew_feeder #(.LANES(LB), .DATA_W(WB)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .ensys_i(ens_b), .bubble_i(bub_b),
        .clr_i(clr_b), .data_i(din_b), .data_o(dout_b), .valid_o(vld_b),
        .busy_o(busy_b), .drained_o(drn_b)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int w      = 0;

    typedef struct {
        int          due;
        int          lane;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    // Run-length stimulus record: n cycles of these inputs, expected busy/drained.
    typedef struct {
        int   n;
        logic ens;
        logic bub;
        logic clr;
        logic busy;
        logic drn;
    } seg_t;
    seg_t tbl[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    endtask

    function automatic logic [15:0] val(input bit sel, input int t, input int k);
        int v;
        v = 10 * t + k;
        if (sel) return v[15:0];
        return {8'h00, v[7:0]};
    endfunction

    task automatic add_seg(input int n, input logic e, input logic b, input logic c,
                           input logic xb, input logic xd);
        seg_t s;
        s.n = n; s.ens = e; s.bub = b; s.clr = c; s.busy = xb; s.drn = xd;
        tbl.push_back(s);
    endtask

    // Called at a falling edge: drive, compare, update scoreboard, advance one clock.
    task automatic step(input bit sel, input logic e, input logic b, input logic c,
                        input logic xb, input logic xd);
        logic [159:0] xdat, adat;
        logic [9:0]   xv, av;
        logic [15:0]  v;
        logic         abusy, adrn;
        int           nl;
        nl = sel ? LB : LA;

        ens_a = sel ? 1'b0 : e; bub_a = sel ? 1'b0 : b; clr_a = sel ? 1'b0 : c;
        ens_b = sel ? e : 1'b0; bub_b = sel ? b : 1'b0; clr_b = sel ? c : 1'b0;
        for (int k = 0; k < LA; k++) begin
            v = val(1'b0, w, k);
            din_a[k*WA +: WA] = sel ? 8'h00 : v[7:0];
        end
        for (int k = 0; k < LB; k++) begin
            v = val(1'b1, w, k);
            din_b[k*WB +: WB] = sel ? v : 16'h0000;
        end
        #1;

        xdat = '0; xv = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                xdat[sb[i].lane*16 +: 16] = sb[i].val;
                xv[sb[i].lane] = 1'b1;
                sb.delete(i);
            end
        end

        adat = '0; av = '0;
        if (sel) begin
            for (int k = 0; k < LB; k++) begin
                adat[k*16 +: 16] = dout_b[k*WB +: WB];
                av[k] = vld_b[k];
            end
            abusy = busy_b; adrn = drn_b;
        end else begin
            for (int k = 0; k < LA; k++) begin
                adat[k*16 +: 16] = {8'h00, dout_a[k*WA +: WA]};
                av[k] = vld_a[k];
            end
            abusy = busy_a; adrn = drn_a;
        end

        check("data_o", adat, xdat);
        check("valid_o", 160'(av), 160'(xv));
        check("busy_o", 160'(abusy), 160'(xb));
        check("drained_o", 160'(adrn), 160'(xd));

        if (c) begin
            sb.delete();
        end else if (e && !b) begin
            for (int k = 0; k < nl; k++) begin
                exp_t en;
                en.due = cyc + 1 + k; en.lane = k; en.val = val(sel, w, k);
                sb.push_back(en);
            end
        end
        w++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_tbl(input bit sel, input int lo, input int hi);
        w = 0;
        for (int i = lo; i < hi; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(sel, tbl[i].ens, tbl[i].bub, tbl[i].clr, tbl[i].busy, tbl[i].drn);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_o"}, 160'(dout_a), 160'(0));
        check({tag, "_valid_o"}, 160'(vld_a), 160'(0));
        check({tag, "_busy_o"}, 160'(busy_a), 160'(0));
        check({tag, "_drained_o"}, 160'(drn_a), 160'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    int s1, s2, s3, s4, s5, s6, s7, s8, s9, s10;

    initial begin
        // ---- stimulus tables: n, ensys, bubble, clr, exp busy, exp drained ----
        // single burst
        add_seg(1, 1, 0, 0, 0, 0); add_seg(9, 1, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 0);
        add_seg(8, 0, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 1); add_seg(3, 0, 0, 0, 0, 0);
        s1 = tbl.size();
        // 3 data words then 7 bubbles
        add_seg(1, 1, 0, 0, 0, 0); add_seg(2, 1, 0, 0, 1, 0); add_seg(7, 1, 1, 0, 1, 0);
        add_seg(1, 0, 0, 0, 1, 0); add_seg(8, 0, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 1);
        add_seg(3, 0, 0, 0, 0, 0);
        s2 = tbl.size();
        // back-to-back batches, 2-cycle gap
        add_seg(1, 1, 0, 0, 0, 0); add_seg(9, 1, 0, 0, 1, 0); add_seg(2, 0, 0, 0, 1, 0);
        add_seg(10, 1, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 0); add_seg(8, 0, 0, 0, 1, 0);
        add_seg(1, 0, 0, 0, 1, 1); add_seg(3, 0, 0, 0, 0, 0);
        s3 = tbl.size();
        // clear mid-burst with ensys held
        add_seg(1, 1, 0, 0, 0, 0); add_seg(4, 1, 0, 0, 1, 0); add_seg(1, 1, 0, 1, 1, 0);
        add_seg(1, 1, 0, 0, 0, 0); add_seg(4, 1, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 0);
        add_seg(8, 0, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 1); add_seg(3, 0, 0, 0, 0, 0);
        s4 = tbl.size();
        // ensys rise together with clear
        add_seg(1, 1, 0, 1, 0, 0); add_seg(1, 1, 0, 0, 0, 0); add_seg(3, 1, 0, 0, 1, 0);
        add_seg(1, 0, 0, 0, 1, 0); add_seg(8, 0, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 1);
        add_seg(2, 0, 0, 0, 0, 0);
        s5 = tbl.size();
        // clear on the last drain cycle: no drained pulse
        add_seg(1, 1, 0, 0, 0, 0); add_seg(9, 1, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 0);
        add_seg(8, 0, 0, 0, 1, 0); add_seg(1, 0, 0, 1, 1, 0); add_seg(3, 0, 0, 0, 0, 0);
        s6 = tbl.size();
        // burst, then part-way into drain (async reset follows)
        add_seg(1, 1, 0, 0, 0, 0); add_seg(9, 1, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 0);
        add_seg(3, 0, 0, 0, 1, 0);
        s7 = tbl.size();
        // idle after reset release
        add_seg(4, 0, 0, 0, 0, 0);
        s8 = tbl.size();
        // 4-lane, 16-bit instance single burst: drain lasts 3 cycles
        add_seg(1, 1, 0, 0, 0, 0); add_seg(9, 1, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 0);
        add_seg(2, 0, 0, 0, 1, 0); add_seg(1, 0, 0, 0, 1, 1); add_seg(3, 0, 0, 0, 0, 0);
        s9 = tbl.size();
        s10 = s9;

        // ---- reset ----
        ens_a = 0; bub_a = 0; clr_a = 0; din_a = '0;
        ens_b = 0; bub_b = 0; clr_b = 0; din_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check_zero("reset");
        check("reset_b_data_o", 160'(dout_b), 160'(0));
        check("reset_b_valid_o", 160'(vld_b), 160'(0));
        check("reset_b_busy_o", 160'(busy_b), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_tbl(1'b0, 0, s1);
        run_tbl(1'b0, s1, s2);
        run_tbl(1'b0, s2, s3);
        run_tbl(1'b0, s3, s4);
        run_tbl(1'b0, s4, s5);
        run_tbl(1'b0, s5, s6);

        // ---- asynchronous reset in the middle of DRAIN ----
        run_tbl(1'b0, s6, s7);
        #1;
        check("pre_reset_busy_o", 160'(busy_a), 160'(1));
        check("pre_reset_any_valid", 160'(|vld_a), 160'(1));
        #1 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        run_tbl(1'b0, s7, s8);

        // ---- 4-lane / 16-bit instance ----
        run_tbl(1'b1, s8, s10);

        check("scoreboard_empty", 160'(sb.size()), 160'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Sits between the global buffer A/B read ports and the 10x10 PE array edge. Two instances are used: one on the A rows, one on the B columns.
- Takes one LANES-wide buffer word per cycle and applies a triangular skew: lane k is delayed k cycles relative to lane 0. This produces the diagonal wavefront the systolic array needs.
- Driven by the controller's ensys/bubble strobes. Provides per-lane valid bits and a drain-complete indication.

Parameters:
- LANES, 10, number of array rows/cols fed (lane count).
- DATA_W, 8, bits per lane element.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ensys_i  in  1  controller systolic enable; high while a batch stream is active.
- bubble_i  in  1  current cycle is a bubble; zero is injected instead of data_i.
- clr_i  in  1  synchronous clear of all delay stages and state; overrides everything except reset.
- data_i  in  LANES*DATA_W  buffer read word; lane k = bits [k*DATA_W +: DATA_W].
- data_o  out  LANES*DATA_W  skewed lane outputs to the array edge.
- valid_o  out  LANES  per-lane: data_o lane carries a real (non-bubble) sample.
- busy_o  out  1  high in ACTIVE or DRAIN.
- drained_o  out  1  one-cycle pulse when DRAIN completes.

Behaviour:
- Reset: all delay stages = 0, data_o = 0, valid_o = 0, busy_o = 0, drained_o = 0, state = IDLE.
- Ingress sample each cycle, as the pair {valid, value}:
  - ensys_i=1, bubble_i=0: {1, data_i lane}.
  - ensys_i=1, bubble_i=1: {0, 0}.
  - ensys_i=0: {0, 0}.
- Lane k datapath: an ingress register followed by k delay stages. Lane k output reflects the ingress sample taken k+1 cycles earlier. Lane 0 latency = 1; lane LANES-1 latency = LANES.
- All stages shift every cycle; there is no stall. Value and valid bits travel together through identical pipelines.
- data_o lane is forced to 0 whenever its valid bit is 0, so PEs never see stale data.
- FSM states IDLE, ACTIVE, DRAIN:
  - IDLE -> ACTIVE when ensys_i=1.
  - ACTIVE -> DRAIN when ensys_i=0. drain_cnt loads LANES-1.
  - ACTIVE stays ACTIVE while ensys_i=1. Bubbles do not leave ACTIVE.
  - DRAIN: drain_cnt decrements each cycle. At drain_cnt==0 go to IDLE and pulse drained_o for one cycle.
  - DRAIN with ensys_i=1 (new batch started before drain finishes): go to ACTIVE, no drained_o pulse. Already-queued samples continue undisturbed.
- drain_cnt width is $clog2(LANES); no wrap past 0.
- clr_i=1:
  - All stages zeroed next cycle; state -> IDLE; drained_o not pulsed.
  - Ingress sample that cycle is discarded.
  - If ensys_i is still high the following cycle, the FSM re-enters ACTIVE normally.
- Reset asserted mid-stream: immediate (asynchronous) return to reset values. No partial output after release.
- busy_o = (state != IDLE), combinational from the state register.
- Simultaneous ensys_i rise and clr_i: clr_i wins. The sample is dropped and state stays IDLE that cycle.

Decomposition:
- Shared package/def header: LANES_DEFAULT (10) and DATA_W_DEFAULT (8), so controller, PE array and feeder agree. Also FSM state encodings IDLE=2'b00, ACTIVE=2'b01, DRAIN=2'b10, consistent with the existing 2-bit state style.
- One natural sub-module: skew_delay_line, parameterised by DEPTH and WIDTH, with a synchronous clear. It is instantiated per lane with DEPTH=k; DEPTH=0 degenerates to a wire.

Test Plan:
1. Single burst: ensys_i high 10 cycles, bubble_i=0, lane k of word t = 10*t+k.
   - Lane 0 shows 0,10,..,90 on cycles 1-10.
   - Lane 9 shows 9,19,..,99 on cycles 10-19; valid_o[9] high exactly on those cycles.
   - drained_o pulses at cycle 10+9 after ensys_i falls; busy_o low the next cycle.
2. Bubble insertion: k=3 data cycles then 7 bubble cycles.
   - Each lane shows exactly 3 valid samples, then zeros with valid low.
   - FSM stays ACTIVE throughout the bubbles.
3. Back-to-back batches: ensys_i drops for 2 cycles (DRAIN entered), then rises again.
   - No drained_o pulse.
   - Second batch lane 9 data appears 10 cycles after its first word; no sample is lost or duplicated.
4. clr_i mid-stream: assert at cycle 5 of a burst.
   - All data_o/valid_o are 0 the next cycle; state IDLE; no drained_o.
   - Holding ensys_i returns the FSM to ACTIVE one cycle later, with lane 0 latency 1.
5. Async reset mid-drain: drop rst_ni between clock edges during DRAIN.
   - Outputs go to 0 immediately, without waiting for a clock edge.
   - After release with ensys_i=0, outputs remain 0 and idle.
6. Parameter sweep LANES=4, DATA_W=16: repeat scenario 1.
   - Lane 3 latency = 4; drain length = 3 cycles.
